// File: rtl/stack_pkg.sv
// stack_pkg: shared definitions for the stack-operation sequencer.
//   stk_op_e  : stk_op encodings (values 6 and 7 are illegal)
//   state_e   : one-hot FSM state encodings
//   STACK_CHECK_WIDTHS(dw, aw) : elaboration-time check that aw == 2*dw
`ifndef STACK_PKG_SV
`define STACK_PKG_SV
`define STACK_CHECK_WIDTHS(dw, aw) \
  if ((aw) != 2*(dw)) begin : g_bad_width \
    $error("stack_seq: AW must equal 2*DW"); \
  end
`endif

package stack_pkg;

  typedef enum logic [2:0] {
    OP_PHA = 3'd0,
    OP_PHP = 3'd1,
    OP_PLA = 3'd2,
    OP_PLP = 3'd3,
    OP_JSR = 3'd4,
    OP_RTS = 3'd5
  } stk_op_e;

  typedef enum logic [6:0] {
    S_IDLE    = 7'b0000001,
    S_PUSH_HI = 7'b0000010,
    S_PUSH_LO = 7'b0000100,
    S_INC     = 7'b0001000,
    S_READ_LO = 7'b0010000,
    S_READ_HI = 7'b0100000,
    S_FIN     = 7'b1000000
  } state_e;

endpackage

// File: rtl/stack_ptr.sv
// stack_ptr: stack pointer register.
//   clk, rst : clock, synchronous active-high reset (sp <= SP_RESET)
//   load/din : overwrite sp (highest priority after reset)
//   dec, inc : sp - 1 / sp + 1, wrapping mod 2^DW
//   sp       : current pointer
module stack_ptr #(
  parameter int            DW       = 8,
  parameter logic [DW-1:0] SP_RESET = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          inc,
  input  logic          dec,
  output logic [DW-1:0] sp
);

  always_ff @(posedge clk) begin
    if (rst)       sp <= SP_RESET;
    else if (load) sp <= din;
    else if (dec)  sp <= sp - DW'(1);
    else if (inc)  sp <= sp + DW'(1);
  end

endmodule

// File: rtl/stack_seq.sv
// stack_seq: sequencer for PHA, PHP, PLA, PLP, JSR, RTS.
//   CLK, R          : clock, synchronous active-high reset
//   start/stk_op    : request (sampled in IDLE only) and op code
//   reg_a, reg_p    : values pushed by PHA / PHP
//   pc_in, target   : JSR return address and destination
//   sp_load/sp_din  : TXS, honoured in IDLE only
//   mem_*           : shared memory port, {PAGE, sp} while busy
//   busy, done, err : handshake back to the core
//   *_load/*_val    : register-load strobes valid in FIN only
//   sp              : current stack pointer
module stack_seq
  import stack_pkg::*;
#(
  parameter int            DW       = 8,
  parameter int            AW       = 16,
  parameter int            P_W      = 4,
  parameter logic [DW-1:0] PAGE     = 8'h01,
  parameter logic [DW-1:0] SP_RESET = 8'hFF
) (
  input  logic           CLK,
  input  logic           R,
  input  logic           start,
  input  logic [2:0]     stk_op,
  input  logic [DW-1:0]  reg_a,
  input  logic [P_W-1:0] reg_p,
  input  logic [AW-1:0]  pc_in,
  input  logic [AW-1:0]  target,
  input  logic           sp_load,
  input  logic [DW-1:0]  sp_din,
  input  logic [DW-1:0]  mem_din,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_dout,
  output logic           mem_we,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           a_load,
  output logic [DW-1:0]  a_val,
  output logic           p_load,
  output logic [P_W-1:0] p_val,
  output logic           pc_load,
  output logic [AW-1:0]  pc_val,
  output logic [DW-1:0]  sp
);

  `STACK_CHECK_WIDTHS(DW, AW)

  state_e        state;
  logic [2:0]    op_q;
  logic [AW-1:0] push_q;  // JSR: return address; PHA/PHP: value in low byte
  logic [AW-1:0] pc_q;
  logic [DW-1:0] lo_q;
  logic          pushing, sp_ld, sp_inc;

  assign busy    = (state != S_IDLE);
  assign pushing = (state == S_PUSH_HI) || (state == S_PUSH_LO);
  assign sp_ld   = sp_load && (state == S_IDLE);
  // RTS walks up a second byte while latching the low half
  assign sp_inc  = (state == S_INC) || ((state == S_READ_LO) && (op_q == OP_RTS));

  stack_ptr #(.DW(DW), .SP_RESET(SP_RESET)) u_sp (
    .clk (CLK),
    .rst (R),
    .load(sp_ld),
    .din (sp_din),
    .inc (sp_inc),
    .dec (pushing),
    .sp  (sp)
  );

  assign mem_addr = busy ? {PAGE, sp} : '0;
  assign mem_dout = !pushing ? '0 :
                    (state == S_PUSH_HI) ? push_q[AW-1:DW] : push_q[DW-1:0];
  // gated combinationally so a reset landing mid-push suppresses that write
  assign mem_we   = pushing && !R;

  assign a_val  = lo_q;
  assign p_val  = lo_q[P_W-1:0];
  assign pc_val = pc_q;

  always_ff @(posedge CLK) begin
    if (R) begin
      state   <= S_IDLE;
      op_q    <= '0;
      push_q  <= '0;
      pc_q    <= '0;
      lo_q    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      a_load  <= 1'b0;
      p_load  <= 1'b0;
      pc_load <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      a_load  <= 1'b0;
      p_load  <= 1'b0;
      pc_load <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          op_q   <= stk_op;
          pc_q   <= target;
          push_q <= (stk_op == OP_JSR) ? pc_in :
                    AW'((stk_op == OP_PHP) ? DW'(reg_p) : reg_a);
          case (stk_op)
            OP_PHA, OP_PHP:         state <= S_PUSH_LO;
            OP_JSR:                 state <= S_PUSH_HI;
            OP_PLA, OP_PLP, OP_RTS: state <= S_INC;
            default: begin
              state <= S_FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          endcase
        end
        S_PUSH_HI: state <= S_PUSH_LO;
        S_PUSH_LO: begin
          state   <= S_FIN;
          done    <= 1'b1;
          pc_load <= (op_q == OP_JSR);
        end
        S_INC: state <= S_READ_LO;
        S_READ_LO: begin
          lo_q <= mem_din;
          if (op_q == OP_RTS) begin
            state <= S_READ_HI;
          end else begin
            state  <= S_FIN;
            done   <= 1'b1;
            a_load <= (op_q == OP_PLA);
            p_load <= (op_q == OP_PLP);
          end
        end
        S_READ_HI: begin
          pc_q    <= {mem_din, lo_q} + AW'(1);
          state   <= S_FIN;
          done    <= 1'b1;
          pc_load <= 1'b1;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: table-driven bench with result and write scoreboards for stack_seq.
module tb_stack_seq;
  import stack_pkg::*;

  logic        CLK = 1'b0;
  logic        R = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  stk_op = '0;
  logic [7:0]  reg_a = '0;
  logic [3:0]  reg_p = '0;
  logic [15:0] pc_in = '0, target = '0;
  logic        sp_load = 1'b0;
  logic [7:0]  sp_din = '0;
  logic [7:0]  mem_din;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_we, busy, done, err, a_load, p_load, pc_load;
  logic [7:0]  a_val, sp;
  logic [3:0]  p_val;
  logic [15:0] pc_val;

  stack_seq dut (
    .CLK(CLK), .R(R), .start(start), .stk_op(stk_op), .reg_a(reg_a), .reg_p(reg_p),
    .pc_in(pc_in), .target(target), .sp_load(sp_load), .sp_din(sp_din), .mem_din(mem_din),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we), .busy(busy), .done(done),
    .err(err), .a_load(a_load), .a_val(a_val), .p_load(p_load), .p_val(p_val),
    .pc_load(pc_load), .pc_val(pc_val), .sp(sp)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [256];
  assign mem_din = mem[mem_addr[7:0]];
  always @(posedge CLK) if (mem_we) mem[mem_addr[7:0]] <= mem_dout;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int nvec = 0, nbad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    nvec++;
    nbad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    int          cyc;
    logic        err;
    logic [2:0]  lds;   // {a_load, p_load, pc_load}
    logic [15:0] val;
    logic [7:0]  sp;
  } exp_t;
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  exp_t eq[$];
  wr_t  wq[$];

  // monitor: samples on the falling edge, pops scoreboards
  always @(negedge CLK) begin
    if (mem_we) begin
      if (wq.size() == 0) fail("unexpected_write");
      else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(w.a));
        chk("wr_data", 32'(mem_dout), 32'(w.d));
      end
    end
    if (done) begin
      if (eq.size() == 0) fail("unexpected_done");
      else begin
        exp_t e;
        e = eq.pop_front();
        chk("latency", cyc, e.cyc);
        chk("err", 32'(err), 32'(e.err));
        chk("loads", 32'({a_load, p_load, pc_load}), 32'(e.lds));
        chk("sp_at_done", 32'(sp), 32'(e.sp));
        chk("busy_in_fin", 32'(busy), 32'd1);
        if (e.lds == 3'b100) chk("a_val", 32'(a_val), 32'(e.val));
        if (e.lds == 3'b010) chk("p_val", 32'(p_val), 32'(e.val));
        if (e.lds == 3'b001) chk("pc_val", 32'(pc_val), 32'(e.val));
      end
    end else begin
      chk("strobe_outside_fin", 32'({err, a_load, p_load, pc_load}), 32'd0);
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [3:0]  p;
    logic [15:0] pc, tgt;
    logic        ld;
    logic [7:0]  din;
    int          n;
    logic        err;
    logic [2:0]  lds;
    logic [15:0] val;
    logic [7:0]  sp;
    int          nw;
    logic [15:0] wa0;
    logic [7:0]  wd0;
    logic [15:0] wa1;
    logic [7:0]  wd1;
  } vec_t;

  vec_t vt[12];

  // call at posedge+#1; drives a request and records its expectations
  task automatic drive(input vec_t v);
    start = 1'b1; stk_op = v.op; reg_a = v.a; reg_p = v.p;
    pc_in = v.pc; target = v.tgt; sp_load = v.ld; sp_din = v.din;
    eq.push_back('{cyc + v.n, v.err, v.lds, v.val, v.sp});
    if (v.nw > 0) wq.push_back('{v.wa0, v.wd0});
    if (v.nw > 1) wq.push_back('{v.wa1, v.wd1});
  endtask

  task automatic wait_done();
    int n = 0;
    while (eq.size() != 0 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (eq.size() != 0) begin
      fail("done_timeout");
      eq.delete();
      wq.delete();
    end
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    @(posedge CLK); #1;
    start = 1'b0; sp_load = 1'b0;
    wait_done();
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    //          op      a      p     pc        tgt       ld din    n  err lds     val       sp    nw wa0       wd0    wa1       wd1
    vt[0]  = '{OP_PHA, 8'h5A, 4'h0, 16'h0000, 16'h0000, 0, 8'h00, 2, 0, 3'b000, 16'h0000, 8'hFE, 1, 16'h01FF, 8'h5A, 16'h0000, 8'h00};
    vt[1]  = '{OP_PLA, 8'h00, 4'h0, 16'h0000, 16'h0000, 0, 8'h00, 3, 0, 3'b100, 16'h005A, 8'hFF, 0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    vt[2]  = '{OP_JSR, 8'h00, 4'h0, 16'h1234, 16'hC000, 0, 8'h00, 3, 0, 3'b001, 16'hC000, 8'hFD, 2, 16'h01FF, 8'h12, 16'h01FE, 8'h34};
    vt[3]  = '{OP_RTS, 8'h00, 4'h0, 16'h0000, 16'h0000, 0, 8'h00, 4, 0, 3'b001, 16'h1235, 8'hFF, 0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    vt[4]  = '{OP_PHP, 8'hCC, 4'hB, 16'h0000, 16'h0000, 1, 8'h00, 2, 0, 3'b000, 16'h0000, 8'hFF, 1, 16'h0100, 8'h0B, 16'h0000, 8'h00};
    vt[5]  = '{OP_PLP, 8'h00, 4'h0, 16'h0000, 16'h0000, 0, 8'h00, 3, 0, 3'b010, 16'h000B, 8'h00, 0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    vt[6]  = '{3'b111, 8'h00, 4'h0, 16'h0000, 16'h0000, 0, 8'h00, 1, 1, 3'b000, 16'h0000, 8'h00, 0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    vt[7]  = '{3'b110, 8'h00, 4'h0, 16'h0000, 16'h0000, 0, 8'h00, 1, 1, 3'b000, 16'h0000, 8'h00, 0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    vt[8]  = '{OP_PHA, 8'hA5, 4'h3, 16'h0000, 16'h0000, 0, 8'h00, 2, 0, 3'b000, 16'h0000, 8'hFF, 1, 16'h0100, 8'hA5, 16'h0000, 8'h00};
    vt[9]  = '{OP_JSR, 8'h00, 4'h0, 16'hFFFF, 16'h0000, 0, 8'h00, 3, 0, 3'b001, 16'h0000, 8'hFD, 2, 16'h01FF, 8'hFF, 16'h01FE, 8'hFF};
    vt[10] = '{OP_RTS, 8'h00, 4'h0, 16'h0000, 16'h0000, 0, 8'h00, 4, 0, 3'b001, 16'h0000, 8'hFF, 0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    vt[11] = '{OP_PLA, 8'h00, 4'h0, 16'h0000, 16'h0000, 1, 8'hFE, 3, 0, 3'b100, 16'h00FF, 8'hFF, 0, 16'h0000, 8'h00, 16'h0000, 8'h00};

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sp", 32'(sp), 32'hFF);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_vals", 32'({a_val, p_val, pc_val}), 32'd0);
    R = 1'b0;
    @(posedge CLK); #1;

    // table: back-to-back ops, each start lands in the IDLE cycle after FIN
    for (int i = 0; i < 12; i++) apply(vt[i]);
    chk("mem_0100", 32'(mem[8'h00]), 32'hA5);

    // start and sp_load pulsed mid-JSR must be ignored
    v = '{OP_JSR, 8'h00, 4'h0, 16'h0102, 16'h0304, 0, 8'h00, 3, 0, 3'b001, 16'h0304, 8'hFD, 2, 16'h01FF, 8'h01, 16'h01FE, 8'h02};
    drive(v);
    @(posedge CLK); #1;
    start = 1'b1; stk_op = OP_PHA; reg_a = 8'h77; sp_load = 1'b1; sp_din = 8'h55;
    @(posedge CLK); #1;
    start = 1'b0; sp_load = 1'b0;
    wait_done();
    @(posedge CLK); #1;
    chk("ignored_start_idle", 32'(busy), 32'd0);
    v = '{OP_RTS, 8'h00, 4'h0, 16'h0000, 16'h0000, 0, 8'h00, 4, 0, 3'b001, 16'h0103, 8'hFF, 0, 16'h0000, 8'h00, 16'h0000, 8'h00};
    apply(v);

    // reset during JSR PUSH_LO aborts: no second write, no load strobe
    wq.push_back('{16'h01FF, 8'h12});
    start = 1'b1; stk_op = OP_JSR; pc_in = 16'h1234; target = 16'hC000;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("t6_push_hi_we", 32'(mem_we), 32'd1);
    @(posedge CLK); #1;
    R = 1'b1;
    #1;
    chk("t6_we_gated", 32'(mem_we), 32'd0);
    @(posedge CLK); #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_sp", 32'(sp), 32'hFF);
    chk("t6_strobes", 32'({done, pc_load}), 32'd0);
    R = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("t6_still_idle", 32'(busy), 32'd0);

    chk("wq_drained", wq.size(), 0);
    chk("eq_drained", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
